// File: rtl/ram_waitstate_ctrl.sv
// Single-port synchronous RAM behind a one-command-at-a-time request/ready controller.
// Every read or write passes through a programmable number of wait states and then pulses
// ready for one cycle. A clear command sweeps the whole array to CLEAR_VALUE.
module ram_waitstate_ctrl #(
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter int unsigned           ADDR_WIDTH  = 16,
  parameter int unsigned           WAIT_STATES = 2,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  ready,
  output logic                  busy,
  output logic                  error
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  // The counter only ever holds WAIT_STATES-1 down to 0.
  localparam int unsigned CntW  = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CntW-1:0] WaitInit =
    (WAIT_STATES > 0) ? CntW'(WAIT_STATES - 1) : '0;
  // One extra pointer bit so the last-location compare cannot wrap back to zero.
  localparam logic [ADDR_WIDTH:0] LastPtr = {1'b0, {ADDR_WIDTH{1'b1}}};

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StAccess,
    StClear,
    StDone
  } state_e;

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic [ADDR_WIDTH:0]     ptr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    op_wr_q;
  logic [DATA_WIDTH-1:0]   out_q;
  logic                    ready_q;
  logic                    busy_q;
  logic                    error_q;

  // No reset on the array so it maps onto block RAM.
  logic [DATA_WIDTH-1:0]   mem [Depth];

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // Control FSM with registered ready/busy/error; reset is checked first on every edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (clear) begin
            state_q <= StClear;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end else if (read && write) begin
            error_q <= 1'b1;
          end else if (read || write) begin
            addr_q  <= address;
            data_q  <= in_data;
            op_wr_q <= write;
            busy_q  <= 1'b1;
            if (WAIT_STATES > 0) begin
              state_q <= StWait;
              cnt_q   <= WaitInit;
            end else begin
              state_q <= StAccess;
            end
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q <= StAccess;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StAccess: begin
          state_q <= StDone;
          ready_q <= 1'b1;
        end
        StClear: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == LastPtr) begin
            state_q <= StDone;
            ready_q <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Single write port shared by committed writes and the clear sweep; suppressed under reset.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = data_q;
    if (!reset) begin
      if (state_q == StAccess && op_wr_q) begin
        mem_we = 1'b1;
      end else if (state_q == StClear) begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q[ADDR_WIDTH-1:0];
        mem_wdata = CLEAR_VALUE;
      end
    end
  end

  // Synchronous write into the array.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read data; only a completed read or reset changes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_q <= '0;
    end else if (state_q == StAccess && !op_wr_q) begin
      out_q <= mem[addr_q];
    end
  end

  assign out_data = out_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign error    = error_q;

endmodule
